// File: rtl/vga_prefetch_if.sv
// Display/memory bundle for the VGA group prefetcher.
//   Display side : vga_read, vga_addr in; vga_data, miss_pulse, miss_count out
//   Memory side  : mem_req, mem_addr out; mem_gnt, mem_rvalid, mem_rdata in
// The master modport is the prefetcher; the slave modport is its environment.
interface vga_prefetch_if #(
    parameter int unsigned ADDR_W = 40
);
    logic              vga_read;
    logic [ADDR_W-1:0] vga_addr;
    logic [79:0]       vga_data;
    logic              miss_pulse;
    logic [15:0]       miss_count;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [15:0]       mem_rdata;

    modport master (
        input  vga_read, vga_addr, mem_gnt, mem_rvalid, mem_rdata,
        output vga_data, miss_pulse, miss_count, mem_req, mem_addr
    );

    modport slave (
        output vga_read, vga_addr, mem_gnt, mem_rvalid, mem_rdata,
        input  vga_data, miss_pulse, miss_count, mem_req, mem_addr
    );
endinterface

// File: rtl/vga_prefetch.sv
// Predictive prefetcher of 10-byte pixel groups for the VGA draw logic.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : vga_prefetch_if.master (display lookup + 16-bit burst memory port)
// Groups are fetched ahead into a small tagged FIFO; the display looks up the
// head entry only. A miss returns zeros, flushes the FIFO and re-aims fetching.
module vga_prefetch #(
    parameter int unsigned ADDR_W = 40,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned BEATS  = 5
) (
    input  logic           clk,
    input  logic           rst,
    vga_prefetch_if.master bus
);
    localparam int unsigned DATA_W = 16 * BEATS;
    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned BEAT_W = $clog2(BEATS + 1);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} fill_state_e;

    fill_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  fetch_ptr_q, fetch_ptr_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0]  asm_q, asm_d;
    logic               abort_q, abort_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DATA_W-1:0]  ent_data_q [DEPTH];
    logic [ADDR_W-1:0]  ent_tag_q  [DEPTH];
    logic [79:0]        vga_data_q, vga_data_d;
    logic               miss_pulse_q, miss_pulse_d;
    logic [15:0]        miss_count_q, miss_count_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic               hit_c, miss_c, push_c, pop_c;
    logic [DATA_W-1:0]  push_data_c;

    // Sequential group address: +10 within a line, else start of next line (line wraps, fb kept).
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (a[7:0] <= 8'd245) next_addr = {a[ADDR_W-1:8], a[7:0] + 8'd10};
        else                  next_addr = {a[ADDR_W-1:16], a[15:8] + 8'd1, 8'h00};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Lookup, fill FSM and FIFO bookkeeping.
    always_comb begin
        state_d      = state_q;
        fetch_ptr_d  = fetch_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        asm_d        = asm_q;
        abort_d      = abort_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        vga_data_d   = vga_data_q;
        miss_pulse_d = 1'b0;
        miss_count_d = miss_count_q;
        mem_addr_d   = mem_addr_q;
        push_c       = 1'b0;
        pop_c        = 1'b0;
        push_data_c  = {bus.mem_rdata, asm_q[DATA_W-17:0]};

        hit_c  = bus.vga_read && (count_q != '0) && (ent_tag_q[rd_ptr_q] == bus.vga_addr);
        miss_c = bus.vga_read && !hit_c;

        case (state_q)
            IDLE: begin
                // A miss in this cycle flushes the FIFO, so a request is always due.
                if (miss_c || (count_q < CNT_W'(DEPTH))) begin
                    state_d    = REQ;
                    abort_d    = 1'b0;
                    mem_addr_d = miss_c ? next_addr(bus.vga_addr) : fetch_ptr_q;
                end
            end
            REQ: begin
                // The request cannot be withdrawn; remember to discard its burst.
                if (miss_c) abort_d = 1'b1;
                if (bus.mem_gnt) begin
                    state_d    = (abort_q || miss_c) ? DRAIN : DATA;
                    beat_cnt_d = '0;
                end
            end
            DATA: begin
                if (bus.mem_rvalid) begin
                    asm_d[16*int'(beat_cnt_q) +: 16] = bus.mem_rdata;
                    beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                    if (beat_cnt_q == BEAT_W'(BEATS - 1)) begin
                        state_d = IDLE;
                        push_c  = !miss_c;
                    end else if (miss_c) begin
                        state_d = DRAIN;
                    end
                end else if (miss_c) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.mem_rvalid) begin
                    if (beat_cnt_q == BEAT_W'(BEATS - 1)) state_d = IDLE;
                    else                                  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (hit_c) begin
            vga_data_d = ent_data_q[rd_ptr_q];
            rd_ptr_d   = ptr_inc(rd_ptr_q);
            pop_c      = 1'b1;
        end
        if (push_c) begin
            wr_ptr_d    = ptr_inc(wr_ptr_q);
            fetch_ptr_d = next_addr(fetch_ptr_q);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (miss_c) begin
            vga_data_d   = '0;
            miss_pulse_d = 1'b1;
            if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            fetch_ptr_d  = next_addr(bus.vga_addr);
        end

        mem_req_d = (state_d == REQ);
    end

    // State and storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            fetch_ptr_q  <= '0;
            beat_cnt_q   <= '0;
            asm_q        <= '0;
            abort_q      <= 1'b0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            vga_data_q   <= '0;
            miss_pulse_q <= 1'b0;
            miss_count_q <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                ent_data_q[i] <= '0;
                ent_tag_q[i]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            fetch_ptr_q  <= fetch_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            asm_q        <= asm_d;
            abort_q      <= abort_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            vga_data_q   <= vga_data_d;
            miss_pulse_q <= miss_pulse_d;
            miss_count_q <= miss_count_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            if (push_c) begin
                ent_data_q[wr_ptr_q] <= push_data_c;
                ent_tag_q[wr_ptr_q]  <= fetch_ptr_q;
            end
        end
    end

    assign bus.vga_data   = vga_data_q;
    assign bus.miss_pulse = miss_pulse_q;
    assign bus.miss_count = miss_count_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
endmodule

// File: tb/tb_vga_prefetch.sv
// Self-checking bench for vga_prefetch: randomised memory latency against a
// queue-based model of the prefetch buffer and fetch address stream.
module tb_vga_prefetch;
    localparam int unsigned AW    = 40;
    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst;

    vga_prefetch_if #(.ADDR_W(AW)) bus ();

    vga_prefetch #(.ADDR_W(AW), .DEPTH(DEPTH), .BEATS(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [AW-1:0] mq[$];
    logic [AW-1:0] req_log[$];
    logic [AW-1:0] m_ptr;
    logic [79:0]   exp_data;
    logic          exp_pulse;
    int unsigned   exp_cnt;
    // Memory responder state
    bit            rsp_busy, rsp_abort, req_seen, req_abort;
    int            rsp_beats;
    int            beat_limit = 5;
    logic [AW-1:0] rsp_addr;
    logic [AW-1:0] last_req;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Framebuffer contents: one byte per address.
    function automatic logic [7:0] mb(input logic [AW-1:0] x);
        return 8'(x[7:0] + 3 * x[15:8] + 7 * x[16]);
    endfunction

    function automatic logic [79:0] grp(input logic [AW-1:0] a);
        logic [79:0] d;
        for (int i = 0; i < 10; i++) d[8*i +: 8] = mb(a + AW'(i));
        return d;
    endfunction

    function automatic logic [15:0] beat(input logic [AW-1:0] a, input int k);
        logic [79:0] d;
        d = grp(a);
        return d[16*k +: 16];
    endfunction

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] a);
        int unsigned off, line;
        off  = int'(a[7:0]);
        line = int'(a[15:8]);
        if (off + 10 <= 255) return a + AW'(10);
        return (a & ~AW'(32'hFFFF)) | AW'(((line + 1) % 256) * 256);
    endfunction

    task automatic model_reset();
        mq.delete();
        req_log.delete();
        m_ptr     = '0;
        exp_data  = '0;
        exp_pulse = 1'b0;
        exp_cnt   = 0;
        rsp_busy  = 0;
        rsp_abort = 0;
        req_seen  = 0;
        req_abort = 0;
        rsp_beats = 0;
    endtask

    // One clock cycle, entered and left at a negedge.
    task automatic tick(input bit rd, input logic [AW-1:0] a);
        bit busy0, gnt, rv, miss, done;
        busy0 = rsp_busy;
        gnt   = 0;
        rv    = 0;
        if (busy0 || mq.size() == DEPTH) check("mem_req_quiet", 80'(bus.mem_req), 80'(0));
        if (bus.mem_req && !busy0) begin
            if (!req_seen) begin
                check("req_addr", 80'(bus.mem_addr), 80'(m_ptr));
                req_seen  = 1;
                req_abort = 0;
                last_req  = bus.mem_addr;
                req_log.push_back(bus.mem_addr);
            end else begin
                check("req_addr_stable", 80'(bus.mem_addr), 80'(last_req));
            end
            if ($urandom_range(0, 2) != 0) begin
                gnt       = 1;
                rsp_busy  = 1;
                rsp_beats = 0;
                rsp_addr  = bus.mem_addr;
                rsp_abort = req_abort;
                req_seen  = 0;
            end
        end
        if (busy0 && rsp_beats < beat_limit && $urandom_range(0, 3) != 0) rv = 1;
        bus.mem_gnt    = gnt;
        bus.mem_rvalid = rv || (!busy0 && $urandom_range(0, 7) == 0);
        bus.mem_rdata  = rv ? beat(rsp_addr, rsp_beats) : 16'($urandom);
        bus.vga_read   = rd;
        bus.vga_addr   = a;

        miss = rd && !(mq.size() > 0 && mq[0] == a);
        done = rv && rsp_beats == 4;
        if (rv) rsp_beats++;
        if (rd && !miss) begin
            exp_data = grp(a);
            void'(mq.pop_front());
        end
        exp_pulse = miss;
        if (miss) begin
            exp_data = '0;
            if (exp_cnt < 65535) exp_cnt++;
            mq.delete();
            m_ptr = nxt(a);
            if (rsp_busy) rsp_abort = 1;
            if (req_seen) req_abort = 1;
        end
        if (done) begin
            if (!rsp_abort && !miss) begin
                mq.push_back(rsp_addr);
                m_ptr = nxt(rsp_addr);
            end
            rsp_busy = 0;
        end

        @(posedge clk);
        #1;
        check("vga_data", bus.vga_data, exp_data);
        check("miss_pulse", 80'(bus.miss_pulse), 80'(exp_pulse));
        check("miss_count", 80'(bus.miss_count), 80'(exp_cnt));
        @(negedge clk);
    endtask

    task automatic read_when_ready(input logic [AW-1:0] a);
        int n = 0;
        while (mq.size() == 0 && n < 300) begin tick(0, '0); n++; end
        check("ready_timeout", 80'(n < 300), 80'(1));
        tick(1, a);
    endtask

    task automatic wait_new_req(input int base);
        int n = 0;
        while (req_log.size() <= base && n < 300) begin tick(0, '0); n++; end
        check("req_timeout", 80'(n < 300), 80'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vga_data"},   bus.vga_data, 80'(0));
        check({tag, "_miss_pulse"}, 80'(bus.miss_pulse), 80'(0));
        check({tag, "_miss_count"}, 80'(bus.miss_count), 80'(0));
        check({tag, "_mem_req"},    80'(bus.mem_req), 80'(0));
        check({tag, "_mem_addr"},   80'(bus.mem_addr), 80'(0));
    endtask

    initial begin
        int n;
        int base;
        logic [AW-1:0] old;

        // Reset
        bus.vga_read   = 0;
        bus.vga_addr   = '0;
        bus.mem_gnt    = 0;
        bus.mem_rvalid = 0;
        bus.mem_rdata  = '0;
        rst = 1'b1;
        #1;
        check_reset_outputs("reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // First group at address 0, then sequential prefetch 0x0A, 0x14
        read_when_ready(40'h0);
        check("first_req_addr", 80'(req_log[0]), 80'(0));
        check("first_group", bus.vga_data, 80'h09080706050403020100);
        check("first_hit_pulse", 80'(bus.miss_pulse), 80'(0));
        wait_new_req(2);
        check("second_req_addr", 80'(req_log[1]), 80'h0A);
        check("third_req_addr", 80'(req_log[2]), 80'h14);

        // Miss re-aims the prefetcher
        tick(1, 40'h10500);
        check("miss_data", bus.vga_data, 80'(0));
        check("miss_pulse_hi", 80'(bus.miss_pulse), 80'(1));
        check("miss_count_1", 80'(bus.miss_count), 80'(1));
        base = req_log.size();
        tick(0, '0);
        check("miss_pulse_lo", 80'(bus.miss_pulse), 80'(0));
        wait_new_req(base);
        check("reaim_addr", 80'(last_req), 80'h1050A);

        // Whole line 3 streams as hits, then wraps to line 4
        tick(1, 40'h300);
        for (int off = 10; off <= 250; off += 10) read_when_ready(40'h300 + AW'(off));
        read_when_ready(40'h400);
        check("line3_no_miss", 80'(bus.miss_count), 80'(2));

        // Line 255 offset 250 wraps to line 0, fb and upper bits preserved
        tick(1, 40'h11FFFA);
        read_when_ready(40'h110000);
        check("line255_wrap", 80'(bus.miss_count), 80'(3));
        check("line255_data", bus.vga_data, grp(40'h110000));

        // Miss two beats into a burst
        beat_limit = 2;
        n = 0;
        while (!(rsp_busy && rsp_beats == 2 && !rsp_abort) && n < 300) begin
            if (mq.size() == DEPTH) tick(1, mq[0]);
            else                    tick(0, '0);
            n++;
        end
        check("midburst_timeout", 80'(n < 300), 80'(1));
        old = rsp_addr;
        tick(1, 40'h2000);
        beat_limit = 5;
        n = 0;
        while (rsp_busy && n < 300) begin tick(0, '0); n++; end
        check("drain_timeout", 80'(n < 300), 80'(1));
        base = req_log.size();
        wait_new_req(base);
        check("post_drain_req", 80'(last_req), 80'h200A);
        tick(1, old);
        check("old_tag_miss", 80'(bus.miss_pulse), 80'(1));

        // Full buffer stalls the fetcher; one pop allows exactly one refill
        n = 0;
        while (!(mq.size() == DEPTH && !rsp_busy) && n < 300) begin tick(0, '0); n++; end
        check("fill_timeout", 80'(n < 300), 80'(1));
        for (int i = 0; i < 20; i++) begin
            tick(0, '0);
            check("full_no_req", 80'(bus.mem_req), 80'(0));
        end
        base = req_log.size();
        tick(1, mq[0]);
        for (int i = 0; i < 60; i++) tick(0, '0);
        check("one_refill", 80'(req_log.size() - base), 80'(1));

        // Miss counter saturation
        for (int i = 0; i < 65537; i++) tick(1, 40'hABCD00);
        check("miss_saturate", 80'(bus.miss_count), 80'hFFFF);

        // Asynchronous reset in the middle of a burst
        n = 0;
        while (!(rsp_busy && rsp_beats >= 1) && n < 300) begin tick(0, '0); n++; end
        check("burst_timeout", 80'(n < 300), 80'(1));
        rst = 1'b1;
        bus.mem_gnt    = 0;
        bus.mem_rvalid = 0;
        bus.vga_read   = 0;
        #1;
        check_reset_outputs("midburst_reset");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        read_when_ready(40'h0);
        check("post_reset_req", 80'(req_log[0]), 80'(0));
        check("post_reset_data", bus.vga_data, 80'h09080706050403020100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
